reg_dump: RTL and testbench
===========================

// Module: reg_dump
// PURPOSE
// - Debug reader on the register file's FPGA inspection port: drives reg_addr, samples reg_output.
// - On a start pulse, walks addresses 0..NUM_REGS-1 and streams a framed byte dump out a valid/ready port.
// - The byte port feeds the board UART TX / host link.
// - Lets the host snapshot R0..R14 and the PC without halting the datapath.
// PARAMETERS
// - NUM_REGS  16    registers dumped, addresses 0..NUM_REGS-1; legal range 1..17
// - HDR_BYTE  8'hA5 frame header byte
// PORTS
// - clk       in   1   sole clock, all state on posedge
// - rst       in   1   asynchronous, active-high reset
// - start     in   1   1-cycle request to begin a dump; sampled only in IDLE
// - busy      out  1   high from the cycle after start is accepted until the cycle done pulses
// - done      out  1   1-cycle pulse after the checksum byte is accepted
// - reg_addr  out  5   address to the register file inspection port
// - reg_data  in   32  register file reg_output; combinational from reg_addr
// - tx_data   out  8   stream byte
// - tx_valid  out  1   tx_data valid
// - tx_ready  in   1   sink accepts; transfer when tx_valid && tx_ready on posedge
// BEHAVIOUR
// - Reset values (async, immediate): state=IDLE, busy=0, done=0, reg_addr=0, tx_valid=0, tx_data=0, checksum=0.
// - Frame:
//   - HDR_BYTE, then per register i: {3'b0,i[4:0]}, data[31:24], [23:16], [15:8], [7:0].
//   - Then CSUM = XOR of every byte after the header.
//   - Length = 2 + 5*NUM_REGS bytes (82 at default).
// - FSM states and transitions:
//   - IDLE -> HDR on start.
//   - HDR: tx_valid=1, tx_data=HDR_BYTE; -> SEL on accept.
//   - SEL: reg_addr<=i; tx_valid=0; 1 cycle -> CAP (read settles one full cycle).
//   - CAP: latch reg_data into 32b shift reg; 1 cycle -> SEND.
//   - SEND: 5 bytes via byte counter 0..4 (addr, then MSB-first data).
//     - XOR each byte into checksum on its accept.
//     - After byte 4 is accepted: i==NUM_REGS-1 -> CSUM, else i++ -> SEL.
//   - CSUM: tx_data=checksum; on accept -> IDLE with done=1 for that one cycle; busy drops the same cycle.
// - Timing: with tx_ready held 1, start to done = 1 + 7*NUM_REGS + 1 + 1 cycles (115 at default).
// - Handshake rules:
//   - Once tx_valid rises, tx_valid and tx_data hold stable until accepted.
//   - tx_valid never drops without a transfer, except on rst.
//   - tx_ready may be asserted with tx_valid=0; this has no effect.
//   - Back-pressure of any length stalls only the FSM; no byte is dropped or duplicated.
// - start: ignored while busy; start coincident with done is ignored; next start is accepted in IDLE.
// - reg_addr:
//   - Changes only on entry to SEL; held through CAP/SEND.
//   - Returns to 0 in IDLE.
//   - Addresses at or above NUM_REGS are never driven.
// - Each register is captured at its own CAP cycle. The dump is not an atomic snapshot across registers.
//   Register file writes between captures are reflected as-is.
// - Checksum clears on leaving IDLE.
// - rst mid-frame: abort at once to the IDLE reset values; no done pulse; the partial frame is discarded by the host.
// TESTING
// - Reg i preloaded 32'h1000_0000+i, tx_ready=1, start
//   -> 82 bytes: A5, 00,10,00,00,00, 01,10,00,00,01 ... 0F,10,00,00,0F, CSUM 00.
//   -> done exactly 115 cycles after start.
// - Same data, tx_ready random 30% duty
//   -> identical 82-byte sequence; tx_data/tx_valid stable every stalled cycle.
// - Regs 0..15 = 32'hDEAD_BEEF except R3 = 0, tx_ready=1
//   -> CSUM = XOR of addrs 0..15 (00) ^ 15x(DE^AD^BE^EF = 22) = 8'h22.
// - start pulsed again at byte 10 and at the done cycle
//   -> ignored, single frame; start 1 cycle after done -> second full frame.
// - rst asserted while tx_valid=1 mid-SEND with tx_ready=0
//   -> tx_valid, busy, reg_addr low same cycle; no done; next start gives a clean frame from A5.
// - NUM_REGS=1, R0 = 32'h1234_5678
//   -> A5,00,12,34,56,78,CSUM 08 (00^12^34^56^78); reg_addr never leaves 0.

Source files
------------

// File: rtl/reg_dump.sv
// reg_dump: debug reader on the register file inspection port.
// A start pulse in IDLE walks addresses 0..NUM_REGS-1. Each register is read
// and streamed out as a framed byte dump on a valid/ready byte port:
//   HDR_BYTE, then {i, d[31:24], d[23:16], d[15:8], d[7:0]} per register,
//   then the XOR of every byte after the header.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           1-cycle dump request, sampled only in IDLE
//   busy, done      frame in progress / 1-cycle completion pulse
//   reg_addr        address to the inspection port
//   reg_data        inspection port read data (combinational from reg_addr)
//   tx_data         output byte
//   tx_valid        output byte is valid
//   tx_ready        sink accepts the byte; a transfer needs tx_valid && tx_ready
module reg_dump #(
   parameter int         NUM_REGS = 16,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  reg_addr,
   input  logic [31:0] reg_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_SEL, S_CAP, S_SEND, S_CSUM
   } state_t;

   state_t      state;
   logic [4:0]  idx;       // register currently being dumped
   logic [2:0]  bcnt;      // byte within the 5-byte register record
   logic [31:0] shreg;     // captured register, shifted out MSB first
   logic [7:0]  checksum;

   wire xfer = tx_valid && tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         reg_addr <= 5'd0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         checksum <= 8'h00;
         idx      <= 5'd0;
         bcnt     <= 3'd0;
         shreg    <= 32'h0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // A start arriving in the done cycle belongs to the old frame.
               if (start && !done) begin
                  state    <= S_HDR;
                  busy     <= 1'b1;
                  checksum <= 8'h00;
                  idx      <= 5'd0;
                  tx_valid <= 1'b1;
                  tx_data  <= HDR_BYTE;
               end
            end
            S_HDR: begin
               if (xfer) begin
                  state    <= S_SEL;
                  tx_valid <= 1'b0;
                  reg_addr <= idx;
               end
            end
            S_SEL: begin
               // reg_addr was driven on entry; give the read a full cycle.
               state <= S_CAP;
            end
            S_CAP: begin
               shreg    <= reg_data;
               bcnt     <= 3'd0;
               tx_valid <= 1'b1;
               tx_data  <= {3'b000, idx};
               state    <= S_SEND;
            end
            S_SEND: begin
               if (xfer) begin
                  checksum <= checksum ^ tx_data;
                  if (bcnt == 3'd4) begin
                     if (idx == LAST_IDX) begin
                        // Fold the final data byte in while loading CSUM.
                        state   <= S_CSUM;
                        tx_data <= checksum ^ tx_data;
                     end else begin
                        state    <= S_SEL;
                        tx_valid <= 1'b0;
                        idx      <= idx + 5'd1;
                        reg_addr <= idx + 5'd1;
                     end
                  end else begin
                     tx_data <= shreg[31:24];
                     shreg   <= {shreg[23:0], 8'h00};
                     bcnt    <= bcnt + 3'd1;
                  end
               end
            end
            S_CSUM: begin
               if (xfer) begin
                  state    <= S_IDLE;
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  reg_addr <= 5'd0;
               end
            end
            default: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               tx_valid <= 1'b0;
               reg_addr <= 5'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: a queue-based frame model built from the register file
// contents at start, checked every cycle against busy/done/tx_* behaviour,
// plus literal expectations for known frames and a NUM_REGS=1 instance.
module tb_reg_dump;
   localparam int NR = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic        st1, busy1, done1, rdy1, txv1;
   logic [4:0]  addr1;
   logic [31:0] data1;
   logic [7:0]  txd1;

   logic [31:0] rf [0:31];
   assign reg_data = rf[reg_addr];
   assign data1    = (addr1 == 5'd0) ? 32'h1234_5678 : 32'hBAD0_BAD0;

   reg_dump #(.NUM_REGS(NR), .HDR_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .reg_addr(reg_addr), .reg_data(reg_data), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready));

   reg_dump #(.NUM_REGS(1), .HDR_BYTE(8'hA5)) dut1 (
      .clk(clk), .rst(rst), .start(st1), .busy(busy1), .done(done1),
      .reg_addr(addr1), .reg_data(data1), .tx_data(txd1),
      .tx_valid(txv1), .tx_ready(rdy1));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ready_mode = 0;   // 0: always ready, 1: ~30% ready, 2: never ready
   int dcount = 0;

   logic [7:0] expq [$];
   logic [7:0] frame [$];
   logic [7:0] ref_frame [$];
   logic [7:0] q1 [$];
   logic       bad1 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tfail(input string name);
      checks++;
      failures++;
      $display("FAIL %s (bound expired or unexpected event)", name);
   endtask

   // Expected frame from the register contents at the moment start is taken.
   function automatic void build_frame();
      logic [7:0]  cs;
      logic [7:0]  b;
      logic [31:0] w;
      expq.delete();
      expq.push_back(8'hA5);
      cs = 8'h00;
      for (int i = 0; i < NR; i++) begin
         w = rf[i];
         b = 8'(i);
         expq.push_back(b);
         cs ^= b;
         for (int k = 3; k >= 0; k--) begin
            b = w[8*k +: 8];
            expq.push_back(b);
            cs ^= b;
         end
      end
      expq.push_back(cs);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      tx_ready = 1'b1;
      else if (ready_mode == 1) tx_ready = ($urandom_range(0, 99) < 30);
      else                      tx_ready = 1'b0;
   end

   // Cycle-by-cycle model: frame in progress flag, expected done, byte queue.
   initial begin : model
      bit         mb, ed, nd, pv, pr;
      logic [7:0] pd, b;
      mb = 0; ed = 0; pv = 0; pr = 0; pd = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mb = 0; ed = 0; pv = 0;
            expq.delete();
         end else begin
            chk("busy", busy, mb);
            chk("done", done, ed);
            if (done) dcount++;
            if (!mb) chk("idle_valid", tx_valid, 0);
            chk("addr_in_range", reg_addr < NR, 1);
            if (pv && !pr) begin
               chk("hold_valid", tx_valid, 1);
               chk("hold_data", tx_data, pd);
            end
            nd = 0;
            if (tx_valid && tx_ready) begin
               frame.push_back(tx_data);
               if (expq.size() == 0) tfail("extra_byte");
               else begin
                  b = expq.pop_front();
                  chk("byte", tx_data, b);
                  if (expq.size() == 0) nd = 1;
               end
            end
            if (start && !mb && !ed) begin
               build_frame();
               frame.delete();
               mb = 1;
            end
            if (nd) mb = 0;
            ed = nd;
            pv = tx_valid; pr = tx_ready; pd = tx_data;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (txv1 && rdy1) q1.push_back(txd1);
         if (addr1 != 5'd0) bad1 = 1'b1;
      end
   end

   task automatic wait_done(input int bound, output int dc);
      bit got;
      got = 0;
      dc = -1;
      for (int k = 0; k < bound; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            got = 1;
            dc = cyc;
            break;
         end
      end
      if (!got) tfail("wait_done");
   endtask

   task automatic run_frame(output int lat);
      int sc, dc;
      @(posedge clk);
      #1;
      start = 1'b1;
      sc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(5000, dc);
      lat = dc - sc;
   endtask

   initial begin : main
      int lat, dc;
      bit got;
      logic [7:0] exp1 [7];
      exp1 = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
      rst = 1'b1; start = 1'b0; st1 = 1'b0; rdy1 = 1'b1; tx_ready = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_valid1", txv1, 0);
      rst = 1'b0;

      // Incrementing pattern, sink always ready.
      for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + i;
      run_frame(lat);
      chk("lat_115", lat, 115);
      chk("len_82", frame.size(), 82);
      if (frame.size() == 82) begin
         chk("f0_hdr", frame[0], 8'hA5);
         chk("f6_addr1", frame[6], 8'h01);
         chk("f7_data", frame[7], 8'h10);
         chk("f10_low", frame[10], 8'h01);
         chk("f76_addr15", frame[76], 8'h0F);
         chk("csum_00", frame[81], 8'h00);
      end
      ref_frame = frame;

      // Same data under random back-pressure: identical byte stream.
      ready_mode = 1;
      run_frame(lat);
      chk("bp_len", frame.size(), ref_frame.size());
      if (frame.size() == ref_frame.size())
         for (int i = 0; i < frame.size(); i++) chk("bp_same", frame[i], ref_frame[i]);

      // DEADBEEF with R3 zero.
      ready_mode = 0;
      for (int i = 0; i < NR; i++) rf[i] = 32'hDEAD_BEEF;
      rf[3] = 32'h0;
      run_frame(lat);
      chk("len_deadbeef", frame.size(), 82);
      if (frame.size() == 82) chk("csum_22", frame[81], 8'h22);

      // Spurious starts mid-frame and in the done cycle; real one just after.
      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      ready_mode = 1;
      dcount = 0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      got = 0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         if (frame.size() >= 10) begin got = 1; break; end
      end
      if (!got) tfail("wait_byte10");
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(5000, dc);
      start = 1'b1;               // coincident with done: ignored
      @(posedge clk);
      #1;                         // one cycle after done: accepted
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(5000, dc);
      chk("two_frames", dcount, 2);
      chk("len_second", frame.size(), 82);

      // Reset mid-SEND with the sink stalled.
      ready_mode = 0;
      for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + i;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      got = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (frame.size() >= 8) begin got = 1; break; end
      end
      if (!got) tfail("wait_byte8");
      ready_mode = 2;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_valid", tx_valid, 1);
      chk("pre_rst_addr", reg_addr, 1);
      rst = 1'b1;
      #1;
      chk("arst_valid", tx_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_addr", reg_addr, 0);
      chk("arst_done", done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ready_mode = 0;
      dcount = 0;
      repeat (4) @(posedge clk);
      chk("no_done_after_rst", dcount, 0);
      run_frame(lat);
      chk("rst_lat", lat, 115);
      chk("rst_len", frame.size(), 82);
      if (frame.size() == 82) chk("rst_hdr", frame[0], 8'hA5);

      // Single-register instance.
      q1.delete();
      @(posedge clk);
      #1 st1 = 1'b1;
      @(posedge clk);
      #1 st1 = 1'b0;
      got = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (done1) begin got = 1; break; end
      end
      if (!got) tfail("wait_done1");
      chk("n1_len", q1.size(), 7);
      if (q1.size() == 7)
         for (int i = 0; i < 7; i++) chk("n1_byte", q1[i], exp1[i]);
      chk("n1_addr_zero", bad1, 0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
